// File: rtl/ppu_oam_scan_if.sv
// OAM read-port bundle between the OAM search unit (master) and OAM memory (slave).
// The master issues a read strobe and byte address; the slave returns the data
// one cycle after the strobe.
interface ppu_oam_scan_if;
  logic       oam_rd;
  logic [7:0] oam_addr;
  logic [7:0] oam_data;

  modport master (output oam_rd, output oam_addr, input oam_data);
  modport slave  (input oam_rd, input oam_addr, output oam_data);
endinterface

// File: rtl/ppu_oam_scan.sv
// ppu_oam_scan: PPU mode-2 OAM search.
// Walks every OAM entry at two cycles per entry (Y byte, then X byte). It keeps
// up to MAX_SPRITES sprites that intersect the latched scanline in a small
// register buffer, which has a combinational random-access read port.
// Optional feature macro: PPU_OAM_XSORT_EN keeps the buffer sorted by ascending
// X (stable on ties) using a parallel compare-and-shift insert.
module ppu_oam_scan #(
  parameter int MAX_SPRITES = 10,
  parameter int OAM_ENTRIES = 40,
  parameter int Y_OFFSET    = 16,
  localparam int CW = $clog2(MAX_SPRITES + 1),
  localparam int IW = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            ly,
  input  logic                  tall,
  ppu_oam_scan_if.master        oam,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         count,
  input  logic [IW-1:0]         buf_idx,
  output logic [7:0]            buf_x,
  output logic [3:0]            buf_row,
  output logic [5:0]            buf_oam
);

  // rd_cnt counts issued reads; it reaches LAST when the final X byte is on the bus.
  localparam int RW   = $clog2(2 * OAM_ENTRIES + 1);
  localparam int LAST = 2 * OAM_ENTRIES;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [RW-1:0]   rd_cnt_reg;
  logic [7:0]      ly_reg;
  logic            tall_reg;
  logic            hit_reg;
  logic [3:0]      row_reg;
  logic [5:0]      cur_e_reg;
  logic [CW-1:0]   count_reg;

  logic [7:0]      buf_x_reg   [MAX_SPRITES];
  logic [3:0]      buf_row_reg [MAX_SPRITES];
  logic [5:0]      buf_oam_reg [MAX_SPRITES];

  logic            launch;
  logic            y_phase;
  logic            x_phase;
  logic            store_en;
  logic [8:0]      ly_biased;
  logic [8:0]      y_wide;
  logic [8:0]      height;
  logic            hit_calc;
  logic [3:0]      row_calc;

  logic            slot_we     [MAX_SPRITES];
  logic [7:0]      slot_x_next [MAX_SPRITES];
  logic [3:0]      slot_row_next [MAX_SPRITES];
  logic [5:0]      slot_oam_next [MAX_SPRITES];

  assign launch   = (state_reg == IDLE) && start;
  // Data on the bus belongs to read rd_cnt-1: odd rd_cnt carries a Y byte, even non-zero an X byte.
  assign y_phase  = (state_reg == SCAN) && rd_cnt_reg[0];
  assign x_phase  = (state_reg == SCAN) && !rd_cnt_reg[0] && (rd_cnt_reg != '0);
  assign store_en = x_phase && hit_reg && (count_reg < CW'(MAX_SPRITES));

  // Hit test in 9 bits so that neither bias nor height addition can wrap.
  assign ly_biased = {1'b0, ly_reg} + 9'(Y_OFFSET);
  assign y_wide    = {1'b0, oam.oam_data};
  assign height    = tall_reg ? 9'd16 : 9'd8;
  assign hit_calc  = (ly_biased >= y_wide) && (ly_biased < (y_wide + height));
  assign row_calc  = 4'(ly_biased - y_wide);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic; start outside IDLE is ignored.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (rd_cnt_reg == RW'(LAST)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state and read counter; address is {entry, 0, phase}.
  always_comb begin
    busy         = (state_reg == SCAN);
    done         = (state_reg == DONE);
    oam.oam_rd   = (state_reg == SCAN) && (rd_cnt_reg < RW'(LAST));
    oam.oam_addr = 8'h00;
    if (oam.oam_rd) oam.oam_addr = 8'({rd_cnt_reg[RW-1:1], 1'b0, rd_cnt_reg[0]});
  end

  // Scan control datapath: latch line parameters, step reads, register the Y hit result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_reg <= '0;
      ly_reg     <= '0;
      tall_reg   <= 1'b0;
      hit_reg    <= 1'b0;
      row_reg    <= '0;
      cur_e_reg  <= '0;
      count_reg  <= '0;
    end else begin
      if (launch) begin
        rd_cnt_reg <= '0;
        ly_reg     <= ly;
        tall_reg   <= tall;
        count_reg  <= '0;
      end else if (state_reg == SCAN) begin
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
      end
      if (y_phase) begin
        hit_reg   <= hit_calc;
        row_reg   <= row_calc;
        cur_e_reg <= 6'(rd_cnt_reg >> 1);
      end
      if (store_en) count_reg <= count_reg + 1'b1;
    end
  end

  // Per-slot write decode.
  generate
    for (genvar gi = 0; gi < MAX_SPRITES; gi++) begin : g_slot
`ifdef PPU_OAM_XSORT_EN
      // Slots holding a strictly larger X move up one place; the new entry lands
      // at the first such slot (or at the tail), so equal X keeps OAM order.
      logic gt;
      logic shift_in;
      assign gt = (CW'(gi) < count_reg) && (buf_x_reg[gi] > oam.oam_data);
      if (gi == 0) begin : g_head
        assign shift_in          = 1'b0;
        assign slot_x_next[gi]   = oam.oam_data;
        assign slot_row_next[gi] = row_reg;
        assign slot_oam_next[gi] = cur_e_reg;
      end else begin : g_body
        assign shift_in          = g_slot[gi-1].gt;
        assign slot_x_next[gi]   = shift_in ? buf_x_reg[gi-1]   : oam.oam_data;
        assign slot_row_next[gi] = shift_in ? buf_row_reg[gi-1] : row_reg;
        assign slot_oam_next[gi] = shift_in ? buf_oam_reg[gi-1] : cur_e_reg;
      end
      assign slot_we[gi] = store_en && (shift_in || gt || (count_reg == CW'(gi)));
`else
      assign slot_we[gi]       = store_en && (count_reg == CW'(gi));
      assign slot_x_next[gi]   = oam.oam_data;
      assign slot_row_next[gi] = row_reg;
      assign slot_oam_next[gi] = cur_e_reg;
`endif
    end
  endgenerate

  // Sprite buffer storage; contents hold until overwritten by a later scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_SPRITES; i++) begin
        buf_x_reg[i]   <= '0;
        buf_row_reg[i] <= '0;
        buf_oam_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_SPRITES; i++) begin
        if (slot_we[i]) begin
          buf_x_reg[i]   <= slot_x_next[i];
          buf_row_reg[i] <= slot_row_next[i];
          buf_oam_reg[i] <= slot_oam_next[i];
        end
      end
    end
  end

  // Combinational buffer read; indices past the buffer read as zero.
  always_comb begin
    buf_x   = 8'h00;
    buf_row = 4'h0;
    buf_oam = 6'h00;
    if (int'(buf_idx) < MAX_SPRITES) begin
      buf_x   = buf_x_reg[buf_idx];
      buf_row = buf_row_reg[buf_idx];
      buf_oam = buf_oam_reg[buf_idx];
    end
  end

  assign count = count_reg;

endmodule

// File: tb/tb_ppu_oam_scan.sv
// Scoreboard bench for ppu_oam_scan: stimulus pushes the expected sprite list
// (computed from the OAM image with plain integer rules); a monitor checks bus
// timing every cycle and pops/compares the buffer when done pulses.
module tb_ppu_oam_scan;
  localparam int MAXS = 10;
  localparam int NE   = 40;
  localparam int YOFF = 16;
  localparam int CW   = $clog2(MAXS + 1);
  localparam int IW   = $clog2(MAXS);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    ly = 8'd0;
  logic          tall = 1'b0;
  logic          busy, done;
  logic [CW-1:0] count;
  logic [IW-1:0] buf_idx = '0;
  logic [7:0]    buf_x;
  logic [3:0]    buf_row;
  logic [5:0]    buf_oam;

  ppu_oam_scan_if oam_bus();

  ppu_oam_scan #(.MAX_SPRITES(MAXS), .OAM_ENTRIES(NE), .Y_OFFSET(YOFF)) dut (
    .clk(clk), .rst(rst), .start(start), .ly(ly), .tall(tall),
    .oam(oam_bus), .busy(busy), .done(done), .count(count),
    .buf_idx(buf_idx), .buf_x(buf_x), .buf_row(buf_row), .buf_oam(buf_oam)
  );

  always #20 clk = ~clk;

  logic [7:0] mem [0:4*NE-1];
  always @(posedge clk) if (oam_bus.oam_rd) oam_bus.oam_data <= mem[oam_bus.oam_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  typedef struct packed { int x; int row; int oam; } ent_t;
  int   exp_start_q[$];
  int   exp_cnt_q[$];
  ent_t exp_ent_q[$];

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: sprite visible on line ly if its top (Y - bias) <= ly < top + height.
  task automatic push_model(int ly_v, bit tall_v, int sc);
    ent_t lst[$];
    ent_t t;
    int h = tall_v ? 16 : 8;
    for (int e = 0; e < NE; e++) begin
      int top = int'(mem[4*e]) - YOFF;
      if (ly_v >= top && ly_v < top + h && lst.size() < MAXS) begin
        t.x = int'(mem[4*e+1]); t.row = ly_v - top; t.oam = e;
        lst.push_back(t);
      end
    end
`ifdef PPU_OAM_XSORT_EN
    for (int i = 1; i < lst.size(); i++)
      for (int j = i; j > 0 && lst[j-1].x > lst[j].x; j--) begin
        t = lst[j]; lst[j] = lst[j-1]; lst[j-1] = t;
      end
`endif
    exp_start_q.push_back(sc);
    exp_cnt_q.push_back(lst.size());
    foreach (lst[i]) exp_ent_q.push_back(lst[i]);
  endtask

  // Monitor: per-cycle bus/status timing, then buffer comparison on the done cycle.
  initial begin
    int off;
    int cnt;
    ent_t t;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_start_q.size() == 0) begin
          chk("idle_busy", busy, 0);
          chk("idle_done", done, 0);
          chk("idle_oam_rd", oam_bus.oam_rd, 0);
        end else begin
          off = cyc - exp_start_q[0];
          chk("busy", busy, int'(off >= 1 && off <= 2*NE+1));
          chk("oam_rd", oam_bus.oam_rd, int'(off >= 1 && off <= 2*NE));
          if (off >= 1 && off <= 2*NE)
            chk("oam_addr", oam_bus.oam_addr, 4*((off-1)/2) + (off-1)%2);
          chk("done", done, int'(off == 2*NE+2));
          if (off >= 2*NE+2) begin
            cnt = exp_cnt_q[0];
            chk("count", count, cnt);
            for (int i = 0; i < cnt; i++) begin
              buf_idx = IW'(i);
              #1;
              t = exp_ent_q.pop_front();
              chk($sformatf("buf_x[%0d]", i), buf_x, t.x);
              chk($sformatf("buf_row[%0d]", i), buf_row, t.row);
              chk($sformatf("buf_oam[%0d]", i), buf_oam, t.oam);
            end
            void'(exp_start_q.pop_front());
            void'(exp_cnt_q.pop_front());
          end
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 4*NE; i++) mem[i] = 8'd0;
  endtask

  task automatic set_ent(int e, int y, int x);
    mem[4*e] = 8'(y); mem[4*e+1] = 8'(x);
  endtask

  // One scan; inputs are scrambled after start to confirm ly/tall are latched.
  task automatic run_scan(string tag, int ly_v, bit tall_v, bit poke);
    int n;
    @(negedge clk);
    ly = 8'(ly_v); tall = tall_v; start = 1'b1;
    push_model(ly_v, tall_v, cyc);
    n = exp_cnt_q[exp_cnt_q.size()-1];
    $display("scan %s: ly=%0d tall=%0d expected_count=%0d", tag, ly_v, tall_v, n);
    @(negedge clk);
    start = 1'b0; ly = 8'($urandom); tall = 1'($urandom);
    if (poke) begin
      repeat (30) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int t = 0; t < 300 && exp_start_q.size() != 0; t++) @(negedge clk);
    chk("scan_complete", exp_start_q.size(), 0);
    if (exp_start_q.size() != 0) begin
      exp_start_q.delete(); exp_cnt_q.delete(); exp_ent_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int ok;
    int lyr;
    // Reset values
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_oam_rd", oam_bus.oam_rd, 0);
    chk("rst_oam_addr", oam_bus.oam_addr, 0);
    chk("rst_count", count, 0);
    buf_idx = IW'(MAXS-1); #1;
    chk("rst_buf_x", buf_x, 0);
    chk("rst_buf_oam", buf_oam, 0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    // All hidden sprites, no hits
    run_scan("all_y0", 0, 1'b0, 1'b1);

    // Overflow: 12 hits, only the first 10 kept
    for (int e = 0; e < 12; e++) set_ent(e, 56, 100 + e);
    run_scan("overflow", 40, 1'b0, 1'b0);

    // Tall vs short sprite, row 12
    clear_mem();
    set_ent(5, 24, 77);
    run_scan("tall", 20, 1'b1, 1'b0);
    run_scan("short", 20, 1'b0, 1'b0);

    // Bottom boundary rows
    clear_mem();
    set_ent(0, 159, 10); set_ent(1, 152, 11); set_ent(2, 151, 12); set_ent(3, 160, 13);
    run_scan("edges", 143, 1'b0, 1'b0);

    // X ordering with ties
    clear_mem();
    set_ent(3, 66, 50); set_ent(7, 66, 20); set_ent(9, 66, 20);
    run_scan("xorder", 50, 1'b0, 1'b0);

    // Randomized OAM images
    for (int r = 0; r < 8; r++) begin
      lyr = $urandom_range(0, 153);
      for (int e = 0; e < NE; e++) begin
        if ($urandom_range(0, 2) == 0) set_ent(e, $urandom_range(0, 255), $urandom_range(0, 7) * 8);
        else set_ent(e, lyr + YOFF - $urandom_range(0, 15), $urandom_range(0, 7) * 8);
      end
      run_scan($sformatf("rand%0d", r), lyr, 1'($urandom), 1'b0);
    end

    // Reset in the middle of a scan
    clear_mem();
    for (int e = 0; e < 6; e++) set_ent(e, 76, 30 + e);
    mon_en = 1'b0;
    @(negedge clk);
    ly = 8'd60; tall = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    buf_idx = '0; #1;
    chk("pre_abort_count", count, 6);
    chk("pre_abort_buf_x", buf_x, 30);
    rst = 1'b0;
    #1;
    $display("abort: reset asserted mid-scan at cycle %0d", cyc);
    chk("abort_busy", busy, 0);
    chk("abort_oam_rd", oam_bus.oam_rd, 0);
    chk("abort_count", count, 0);
    chk("abort_done", done, 0);
    chk("abort_buf_x", buf_x, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ok = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done || busy) ok = 0;
    end
    chk("abort_no_done", ok, 1);
    mon_en = 1'b1;
    run_scan("after_abort", 60, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
